// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: opcode/funct constants and fetch-state encoding shared with the control FSM.
package instr_fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} fetch_state_t;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_JR    = 6'h08;
endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational next-PC selection (JR > jump > taken branch > fall-through).
module next_pc_sel
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] ir,
    input  logic [31:0] reg_rs,
    input  logic        jump,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    output logic [31:0] next_pc,
    output logic        jr_misaligned
);
    logic        is_jr;
    logic        take_br;
    logic [31:0] br_off;

    assign is_jr         = jump && ir[31:26] == OP_RTYPE && ir[5:0] == FN_JR;
    assign take_br       = (beq && zero) || (bne && !zero);
    assign br_off        = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign jr_misaligned = is_jr && |reg_rs[1:0];
    // A misaligned JR target is still taken, with its low bits cleared.
    assign next_pc = is_jr   ? {reg_rs[31:2], 2'b00} :
                     jump    ? {pc_plus4[31:28], ir[25:0], 2'b00} :
                     take_br ? pc_plus4 + br_off : pc_plus4;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch FSM with ack timeout, PC/IR registers and sticky error flags.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        pc_we,
    input  logic        jump,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    input  logic [31:0] reg_rs,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        ir_valid,
    output logic        busy,
    output logic [1:0]  err
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    fetch_state_t  state, state_nxt;
    logic [31:0]   ir;
    logic [31:0]   next_pc;
    logic [WW-1:0] wait_cnt;
    logic          upd_done;
    logic          jr_misaligned;
    logic          pc_upd;
    logic          timeout;

    assign imem_req  = state == REQ;
    assign busy      = state != IDLE;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign opcode    = ir[31:26];
    assign rs        = ir[25:21];
    assign rt        = ir[20:16];
    assign rd        = ir[15:11];
    assign imm       = ir[15:0];
    assign funct     = ir[5:0];
    assign timeout   = imem_req && !imem_ack && wait_cnt == WW'(MAX_WAIT - 1);
    // One PC update per fetched instruction, only while the fetch engine is idle.
    assign pc_upd    = pc_we && ir_valid && !upd_done && !busy;

    next_pc_sel u_next_pc_sel (
        .pc_plus4      (pc_plus4),
        .ir            (ir),
        .reg_rs        (reg_rs),
        .jump          (jump),
        .beq           (beq),
        .bne           (bne),
        .zero          (zero),
        .next_pc       (next_pc),
        .jr_misaligned (jr_misaligned)
    );

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nxt;

    always_comb begin
        state_nxt = IDLE;
        state_nxt = state == IDLE ? (fetch_en ? REQ : IDLE) :
                    state == REQ  ? (imem_ack ? DONE : timeout ? IDLE : REQ) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            ir       <= '0;
            ir_valid <= 1'b0;
            upd_done <= 1'b0;
            err      <= 2'b00;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= imem_req ? wait_cnt + 1'b1 : '0;
            if (imem_req && imem_ack) begin
                ir       <= imem_rdata;
                ir_valid <= 1'b1;
                upd_done <= 1'b0;
            end
            if (timeout) err[0] <= 1'b1;
            if (pc_upd) begin
                pc       <= next_pc;
                ir_valid <= 1'b0;
                upd_done <= 1'b1;
                if (jr_misaligned) err[1] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vectors checked against a cycle-level behavioural model plus literal expectations.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0, pc_we = 1'b0, jump = 1'b0, beq = 1'b0, bne = 1'b0, zero = 1'b0;
    logic [31:0] reg_rs = '0, imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        imem_req, ir_valid, busy;
    logic [31:0] imem_addr, pc, pc_plus4;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [1:0]  err;

    int n_checks = 0;
    int n_fail = 0;

    instr_fetch #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_we(pc_we), .jump(jump),
        .beq(beq), .bne(bne), .zero(zero), .reg_rs(reg_rs), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .pc(pc), .pc_plus4(pc_plus4), .ir_valid(ir_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 waiting for ack, 2 instruction just delivered.
    logic        m_on = 1'b0;
    int          m_phase, m_waited;
    logic [31:0] m_pc, m_ir;
    logic        m_valid, m_upd;
    logic [1:0]  m_err;

    function automatic logic is_jr(input logic j, input logic [31:0] i);
        return j && i[31:26] == 6'h00 && i[5:0] == 6'h08;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] i,
            input logic j, input logic b, input logic n, input logic z, input logic [31:0] r);
        logic [31:0] p4;
        int off;
        p4 = p + 32'd4;
        off = $signed(i[15:0]);
        if (is_jr(j, i)) return r & ~32'd3;
        if (j) return (p4 & 32'hF000_0000) | ({6'd0, i[25:0]} * 32'd4);
        if ((b && z) || (n && !z)) return p4 + 32'(off * 4);
        return p4;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_on <= 1'b1; m_phase <= 0; m_waited <= 0; m_pc <= RESET_PC; m_ir <= '0;
            m_valid <= 1'b0; m_upd <= 1'b0; m_err <= 2'b00;
        end else if (m_phase == 0) begin
            if (fetch_en) begin
                m_phase <= 1;
                m_waited <= 0;
            end
            if (pc_we && m_valid && !m_upd) begin
                m_pc <= model_next(m_pc, m_ir, jump, beq, bne, zero, reg_rs);
                m_valid <= 1'b0;
                m_upd <= 1'b1;
                if (is_jr(jump, m_ir) && reg_rs[1:0] != 2'b00) m_err[1] <= 1'b1;
            end
        end else if (m_phase == 1) begin
            if (imem_ack) begin
                m_ir <= imem_rdata; m_valid <= 1'b1; m_upd <= 1'b0; m_phase <= 2;
            end else if (m_waited + 1 == MAX_WAIT) begin
                m_phase <= 0; m_err[0] <= 1'b1;
            end else m_waited <= m_waited + 1;
        end else m_phase <= 0;
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_phase == 1});
            chk("busy", {31'd0, busy}, {31'd0, m_phase != 0});
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("ir_fields", {opcode, rs, rt, imm}, m_ir);
            chk("rd_funct", {21'd0, rd, funct}, {21'd0, m_ir[15:11], m_ir[5:0]});
            chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_valid});
            chk("err", {30'd0, err}, {30'd0, m_err});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] data, input int delay);
        fetch_en = 1'b1;
        tick();
        repeat (delay) tick();
        imem_ack = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack = 1'b0;
        fetch_en = 1'b0;
        tick();
    endtask

    task automatic upd(input logic j, input logic b, input logic n, input logic z,
            input logic [31:0] r, input int cycles);
        jump = j; beq = b; bne = n; zero = z; reg_rs = r; pc_we = 1'b1;
        repeat (cycles) tick();
        jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0; reg_rs = '0; pc_we = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("reset_pc", pc, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, ir_valid}, 32'd0);
        // Ack in first REQ cycle; pc_we during DONE is ignored.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'h2008_0005;
        tick();
        imem_ack = 1'b0;
        chk("lat_opcode", {26'd0, opcode}, 32'h08);
        chk("lat_imm", {16'd0, imm}, 32'h5);
        chk("lat_valid", {31'd0, ir_valid}, 32'd1);
        pc_we = 1'b1;
        tick();
        chk("busy_pc_we", pc, 32'h0);
        tick();
        pc_we = 1'b0;
        chk("first_upd", pc, 32'h4);
        fetch(32'h0800_0004, 3);
        upd(1, 0, 0, 0, 0, 1);
        chk("j_to_10", pc, 32'h10);
        fetch(32'h1000_FFFF, 0);
        upd(0, 1, 0, 1, 0, 3);
        chk("beq_back", pc, 32'h10);
        fetch(32'h1400_0003, 1);
        upd(0, 0, 1, 1, 0, 1);
        chk("bne_not_taken", pc, 32'h14);
        fetch(32'h1400_0003, 0);
        upd(0, 0, 1, 0, 0, 1);
        chk("bne_taken", pc, 32'h24);
        fetch(32'h0000_0008, 2);
        upd(1, 0, 0, 0, 32'h1000_0000, 1);
        chk("jr_aligned", pc, 32'h1000_0000);
        fetch(32'h0800_0040, 0);
        upd(1, 0, 0, 0, 0, 1);
        chk("j_region", pc, 32'h1000_0100);
        fetch(32'h0000_0008, 0);
        upd(1, 0, 0, 0, 32'h0000_0022, 1);
        chk("jr_misaligned", pc, 32'h20);
        chk("err_jr", {30'd0, err}, 32'd2);
        fetch(32'h0000_0008, 0);
        upd(1, 0, 0, 0, 32'hFFFF_FFFC, 1);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        chk("pc4_wrap", pc_plus4, 32'h0);
        fetch(32'h0800_0008, 0);
        upd(1, 0, 0, 0, 0, 1);
        chk("j_not_jr", pc, 32'h20);
        // Timeout leaves the previously fetched instruction valid.
        fetch(32'h2008_0005, 0);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        repeat (MAX_WAIT - 1) tick();
        chk("to_still_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("to_idle", {31'd0, busy}, 32'd0);
        chk("to_err", {30'd0, err}, 32'd3);
        chk("to_valid", {31'd0, ir_valid}, 32'd1);
        chk("to_opcode", {26'd0, opcode}, 32'h08);
        fetch(32'h3C01_1234, 1);
        chk("refetch_op", {26'd0, opcode}, 32'h0F);
        chk("refetch_imm", {16'd0, imm}, 32'h1234);
        // Reset in REQ with ack in the same cycle, then a stale ack.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        tick();
        reset = 1'b0;
        chk("rst_ir", {opcode, rs, rt, imm}, 32'h0);
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        imem_ack = 1'b0;
        chk("stale_ack", {31'd0, ir_valid}, 32'd0);
        fetch(32'h2008_0005, 0);
        upd(0, 0, 0, 0, 0, 1);
        chk("post_rst_upd", pc, 32'h4);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded at reset.
REQ-002 SHALL have parameter MAX_WAIT, default 15, the maximum number of cycles to wait for imem_ack before flagging a timeout.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- fetch_en  in  1  fetch request from the control FSM (its instrReg).
- pc_we  in  1  PC update enable from the control FSM (its PCReg).
- jump  in  1  jump request for J, JAL or JR.
- beq  in  1  branch-if-equal request.
- bne  in  1  branch-if-not-equal request.
- zero  in  1  ALU zero flag.
- reg_rs  in  32  rs register value, used by JR.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  read address; always equals pc.
- imem_rdata  in  32  read data.
- imem_ack  in  1  read data valid.
- opcode  out  6  IR[31:26].
- funct  out  6  IR[5:0].
- rs  out  5  IR[25:21].
- rt  out  5  IR[20:16].
- rd  out  5  IR[15:11].
- imm  out  16  IR[15:0].
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4; this is the JAL link value.
- ir_valid  out  1  IR holds the instruction fetched from pc.
- busy  out  1  fetch in progress.
- err  out  2  sticky error flags: bit0 = timeout, bit1 = misaligned JR target.

Function
REQ-005 Fetch FSM states SHALL be IDLE, REQ and DONE.
- IDLE -> REQ on fetch_en.
- REQ -> DONE on imem_ack.
- DONE -> IDLE unconditionally.
REQ-006 imem_req SHALL be high only in REQ; busy SHALL be high in REQ and DONE.
REQ-007 On imem_ack in REQ, IR SHALL capture imem_rdata, and ir_valid SHALL go high the next cycle.
- Minimum latency is fetch_en to ir_valid = 2 cycles when ack arrives in the first REQ cycle.
REQ-008 fetch_en asserted while busy SHALL be ignored.
REQ-009 Timeout: after MAX_WAIT REQ cycles without ack, the FSM SHALL return to IDLE and set err[0].
- IR and ir_valid SHALL be unchanged on timeout.
REQ-010 PC SHALL update at most once per fetched instruction.
- The update happens on the first pc_we cycle with ir_valid=1 and upd_done=0.
- Each update sets upd_done; each new imem_ack clears it.
- Later pc_we pulses before the next fetch SHALL be ignored.
REQ-011 Next-PC priority:
- JR (jump and opcode=0 and funct=6'h08): reg_rs.
- Else jump: {pc_plus4[31:28], IR[25:0], 2'b00}.
- Else (beq and zero) or (bne and not zero): pc_plus4 + (sign-extended imm << 2), 32-bit wrap-around.
- Else: pc_plus4.
REQ-012 JR with reg_rs[1:0] != 0 SHALL set err[1] and still load reg_rs with bits [1:0] forced to 0.
REQ-013 pc_we while busy SHALL be ignored and SHALL NOT set upd_done.
REQ-014 ir_valid SHALL drop when the PC updates and stay low until the next ack.
REQ-015 pc_plus4 SHALL wrap from 32'hFFFF_FFFC to 32'h0.

Reset
REQ-016 On reset:
- pc = RESET_PC.
- IR = 0.
- FSM = IDLE.
- ir_valid = 0, upd_done = 0, err = 0, imem_req = 0, busy = 0.
REQ-017 Reset SHALL override every other input in the same cycle, including mid-fetch.
- An imem_ack in the reset cycle or after it is discarded until a new fetch_en.

Structure
REQ-018 The opcode and funct constants (J=6'h2, JAL=6'h3, BEQ=6'h4, BNE=6'h5, JR funct=6'h08, Rtype=6'h0) and the fetch-state encodings SHALL live in a shared package also used by the control FSM.
REQ-019 Next-PC selection SHALL be one combinational sub-module, next_pc_sel; the FSM, PC, IR and flags SHALL stay in instr_fetch.

Verification
REQ-020 Reset, then fetch_en with ack on the first REQ cycle and rdata=32'h2008_0005:
- opcode=6'h08, imm=16'h0005 and ir_valid=1 two cycles after fetch_en.
- Then one pc_we gives pc=32'h4.
REQ-021 pc=32'h10, BEQ imm=16'hFFFF, zero=1, pc_we held for 3 cycles:
- pc=32'h10 after exactly one update (0x14 - 4); no further change.
REQ-022 J with IR[25:0]=26'h0000040 at pc=32'h1000_0000, pc_we:
- pc=32'h1000_0100.
REQ-023 JR with reg_rs=32'h0000_0022:
- pc=32'h0000_0020 and err[1]=1.
REQ-024 fetch_en with no ack for MAX_WAIT=15 cycles:
- FSM back in IDLE, err[0]=1, ir_valid unchanged.
- A second fetch_en then acked completes normally.
REQ-025 Reset asserted in REQ with ack in the same cycle:
- IR=0, ir_valid=0, pc=RESET_PC, busy=0 the next cycle.
